// File: rtl/lab7soc_key_capture_if.sv
// Avalon-MM slave bus bundle for the key-capture PIO.
//   address     master->slave  word address
//   chipselect  master->slave  access select
//   write_n     master->slave  write strobe, active low
//   writedata   master->slave  write payload
//   readdata    slave->master  read payload, zero wait states
interface lab7soc_key_capture_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/lab7soc_key_capture.sv
// Input PIO for push-buttons/switches: two-flop synchroniser, per-bit debounce,
// sticky edge capture with write-1-to-clear, and a maskable level IRQ.
// Register map: 0 data (stable), 1 direction (reads 0), 2 irq_mask, 3 edge_capture.
//   clk      system clock
//   reset_n  synchronous reset, active low
//   avs      Avalon-MM slave bus (readdata is combinational from address)
//   in_port  asynchronous external inputs
//   irq      level interrupt, |(edge_capture & irq_mask)
module lab7soc_key_capture #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned RESET_LEVEL     = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  lab7soc_key_capture_if.slave   avs,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RST_VAL  = (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic             wr_c;
  logic [WIDTH-1:0] rise_c, fall_c, hit_c, clr_c;

  // Upper writedata bits carry nothing for narrow ports.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^avs.writedata[31:WIDTH];
  end

  assign wr_c = avs.chipselect && !avs.write_n;

  // Debounce: a bit's stable value flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge selection, W1C and mask writes; a new capture beats a same-edge clear.
  always_comb begin
    rise_c = stable_d & ~stable_q;
    fall_c = ~stable_d & stable_q;
    hit_c  = rise_c | fall_c;
    if (EDGE_TYPE == 0) begin
      hit_c = rise_c;
    end else if (EDGE_TYPE == 1) begin
      hit_c = fall_c;
    end
    clr_c  = '0;
    mask_d = mask_q;
    if (wr_c && avs.address == 2'd2) begin
      mask_d = avs.writedata[WIDTH-1:0];
    end
    if (wr_c && avs.address == 2'd3) begin
      clr_c = avs.writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~clr_c) | hit_c;
  end

  // Zero-wait-state read mux.
  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0:    avs.readdata = 32'(stable_q);
      2'd1:    avs.readdata = '0;
      2'd2:    avs.readdata = 32'(mask_q);
      default: avs.readdata = 32'(edge_q);
    endcase
  end

  assign irq = |(edge_q & mask_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      edge_q   <= '0;
      mask_q   <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
